i2c_master_rw: RTL and testbench
================================

I2C_MASTER_RW -- requirements
Module: i2c_master_rw

Interface
REQ-001 SHALL have parameter HALF, default 249, meaning half-SCL-period count minus 1 (10 us SCL at 50 MHz).
REQ-002 SHALL have parameter QUTR, default 124, meaning quarter-SCL-period count minus 1.
REQ-003 SHALL have parameter MAX_BYTES, default 4, meaning the largest transfer length in bytes, including the address byte; legal range 2..8.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have port din, input, 8*MAX_BYTES bits: byte 0 in the MSBs is the address byte {addr[6:0], rw}; following bytes are write data.
REQ-007 SHALL have port nbytes, input, 4 bits, meaning total bytes including the address; legal range 1..MAX_BYTES.
REQ-008 SHALL have port wr_i2c, input, 1 bit, meaning a start request; it is sampled only in IDLE.
REQ-009 SHALL have port dout, output, 8*(MAX_BYTES-1) bits, meaning read bytes packed first-received in the MSBs.
REQ-010 SHALL have port i2c_sclk, inout, 1 bit: open-drain SCL, driven 0 or Z.
REQ-011 SHALL have port i2c_sdat, inout, 1 bit: open-drain SDA, driven 0 or Z.
REQ-012 SHALL have ports i2c_idle, i2c_fail and i2c_done_tick, each output, 1 bit, meaning idle level, NACK-seen level and end-of-transfer pulse respectively.

Function
REQ-013 SHALL implement the states IDLE, START, SCL_BEGIN, DATA1, DATA2, DATA3, ACK1, ACK2, ACK3, SCL_END, STOP and TURN; every non-IDLE state lasts QUTR+1 cycles (SCL low) or HALF+1 cycles (SCL high).
REQ-014 SHALL take IDLE -> START on wr_i2c=1 when 1 <= nbytes <= MAX_BYTES, latching din and nbytes, clearing the bit/byte counters and clearing i2c_fail; wr_i2c with an illegal nbytes SHALL be ignored.
REQ-015 SHALL produce START as SDA low with SCL high for HALF+1 cycles, and SCL_BEGIN as SCL low for QUTR+1 cycles.
REQ-016 SHALL transmit each write bit MSB-first as DATA1 (SCL low), DATA2 (SCL high) and DATA3 (SCL low), holding SDA stable for all three phases.
REQ-017 SHALL release SDA in DATA1-3 for read bytes (rw=1, byte index >= 1) and sample SDA into the shift register at the last cycle of DATA2.
REQ-018 SHALL, for write bytes and the address byte, release SDA in ACK1-3 and sample the slave ACK at the last cycle of ACK2; a sampled 1 SHALL set i2c_fail and route ACK3 -> SCL_END.
REQ-019 SHALL, for read bytes, drive SDA=0 (ACK) in ACK1-3 for every byte except the last, which SHALL be NACK (SDA released); i2c_fail is unaffected by read ACKs.
REQ-020 SHALL route ACK3 -> SCL_END when byte index == nbytes-1, otherwise back to DATA1 with the byte index incremented; nbytes=1 sends the address only.
REQ-021 SHALL produce SCL_END as SCL low, SDA low; STOP as SCL high, SDA low; then release SDA; TURN as an idle bus for HALF+1 cycles, after which i2c_done_tick SHALL be high for exactly 1 cycle and the state returns to IDLE.
REQ-022 SHALL implement clock stretching: in any SCL-high state the cycle counter SHALL hold at 0 while the synchronised SCL input reads 0.
REQ-023 SHALL hold dout stable from transfer end until the next accepted wr_i2c; unread byte slots SHALL be zero.
REQ-024 SHALL assert i2c_idle combinationally only in IDLE.
REQ-025 SHALL register the SDA and SCL drive values (glitch-free) and pass sampled bus inputs through a 2-flop synchroniser.

Reset
REQ-026 SHALL, while reset_n=0, immediately force IDLE, SDA/SCL released, all counters 0, data/dout 0, i2c_fail=1 and i2c_done_tick=0.
REQ-027 SHALL abandon a transfer on reset mid-operation without generating STOP; the bus is released only.

Structure
REQ-028 SHALL place the state encoding and the default HALF/QUTR values in the shared package i2c_pkg.
REQ-029 SHALL instantiate the sub-module i2c_sync (2-flop synchroniser, 2 bits wide) for SCL and SDA input sampling.

Verification
REQ-030 SHALL verify a write: din[31:24]=8'h34, data 8'h1E/8'h00, nbytes=3, ACKing slave -> 27 SCL pulses, i2c_fail=0, one done tick at 500*27+~1000 cycles.
REQ-031 SHALL verify a read: address 8'h35, nbytes=3, slave returns 8'hA5 then 8'h3C -> dout MSBs = 16'hA53C, master ACK after byte 1 and NACK after byte 2.
REQ-032 SHALL verify a NACK: slave NACKs the address -> i2c_fail=1, STOP follows ACK3 directly, no data bits sent, done tick issued.
REQ-033 SHALL verify clock stretching: slave holds SCL low for 1000 cycles in the DATA2 of bit 3 -> the SCL-high phase lasts 1000+HALF+1 cycles (plus synchroniser lag), with data intact.
REQ-034 SHALL verify reset mid-DATA2: reset_n pulsed low -> both lines released within the same cycle, i2c_idle=1 after release, and a subsequent transfer completes correctly.
REQ-035 SHALL verify boundary requests: nbytes=0 or MAX_BYTES+1 -> stays IDLE; wr_i2c held high through the transfer -> exactly one transfer per IDLE visit.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read/write master: FSM encoding and default bus timing.
package i2c_pkg;

    localparam int unsigned HalfDefault = 249;
    localparam int unsigned QutrDefault = 124;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StSclBegin,
        StData1,
        StData2,
        StData3,
        StAck1,
        StAck2,
        StAck3,
        StSclEnd,
        StStop,
        StTurn
    } state_e;

    // States in which the master releases SCL; these are the ones that honour stretching.
    function automatic logic scl_high(input state_e st);
        return st inside {StIdle, StStart, StData2, StAck2, StStop, StTurn};
    endfunction

endpackage

// File: rtl/i2c_sync.sv
// Two-flop synchroniser for the sampled bus lines; resets to the idle (high) bus level.
module i2c_sync #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2c_master_rw.sv
// I2C master issuing one addressed write or read transfer of up to MAX_BYTES bytes,
// with open-drain registered bus drives and SCL clock-stretching support.
module i2c_master_rw
    import i2c_pkg::*;
#(
    parameter int unsigned HALF      = HalfDefault,
    parameter int unsigned QUTR      = QutrDefault,
    parameter int unsigned MAX_BYTES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [8*MAX_BYTES-1:0]     din,
    input  logic [3:0]                 nbytes,
    input  logic                       wr_i2c,
    output logic [8*(MAX_BYTES-1)-1:0] dout,
    inout  wire                        i2c_sclk,
    inout  wire                        i2c_sdat,
    output logic                       i2c_idle,
    output logic                       i2c_fail,
    output logic                       i2c_done_tick
);

    localparam int unsigned TxW  = 8 * MAX_BYTES;
    localparam int unsigned RxW  = 8 * (MAX_BYTES - 1);
    localparam logic [3:0]  MaxB = 4'(MAX_BYTES);

    state_e           state_q, state_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [3:0]       byte_q, byte_d;
    logic [3:0]       nbytes_q, nbytes_d;
    logic             rw_q, rw_d;
    logic [TxW-1:0]   tx_q, tx_d;
    logic [RxW-1:0]   rx_q, rx_d;
    logic [RxW-1:0]   dout_q, dout_d;
    logic             fail_q, fail_d;
    logic             done_q, done_d;
    logic             sda_q, sda_d;
    logic             scl_q, scl_d;

    logic [1:0] bus_sync;
    logic       scl_in, sda_in;
    logic       high, step, last, rd_byte, last_byte;
    logic [6:0] shamt;

    i2c_sync #(
        .Width(2)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      ({i2c_sclk, i2c_sdat}),
        .q      (bus_sync)
    );

    assign scl_in = bus_sync[1];
    assign sda_in = bus_sync[0];

    // A slave holding SCL low freezes the counter of any SCL-high phase at zero.
    assign high      = scl_high(state_q);
    assign step      = !(high && !scl_in);
    assign last      = step && (cnt_q == (high ? 16'(HALF) : 16'(QUTR)));
    assign rd_byte   = rw_q && (byte_q != 4'd0);
    assign last_byte = (byte_q == nbytes_q - 4'd1);
    assign shamt     = {MaxB - nbytes_q, 3'b000};

    always_comb begin
        state_d  = state_q;
        cnt_d    = (!step || last) ? 16'd0 : cnt_q + 16'd1;
        bit_d    = bit_q;
        byte_d   = byte_q;
        nbytes_d = nbytes_q;
        rw_d     = rw_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        dout_d   = dout_q;
        fail_d   = fail_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 16'd0;
                if (wr_i2c && (nbytes != 4'd0) && (nbytes <= MaxB)) begin
                    state_d  = StStart;
                    tx_d     = din;
                    nbytes_d = nbytes;
                    rw_d     = din[TxW-8];
                    bit_d    = 3'd0;
                    byte_d   = 4'd0;
                    rx_d     = '0;
                    fail_d   = 1'b0;
                end
            end
            StStart:    if (last) state_d = StSclBegin;
            StSclBegin: if (last) state_d = StData1;
            StData1:    if (last) state_d = StData2;
            StData2: begin
                if (last) begin
                    if (rd_byte) rx_d = {rx_q[RxW-2:0], sda_in};
                    state_d = StData3;
                end
            end
            StData3: begin
                if (last) begin
                    if (!rd_byte) tx_d = tx_q << 1;
                    bit_d   = bit_q + 3'd1;
                    state_d = (bit_q == 3'd7) ? StAck1 : StData1;
                end
            end
            StAck1: if (last) state_d = StAck2;
            StAck2: begin
                if (last) begin
                    if (!rd_byte && sda_in) fail_d = 1'b1;
                    state_d = StAck3;
                end
            end
            StAck3: begin
                if (last) begin
                    if (fail_q || last_byte) begin
                        state_d = StSclEnd;
                    end else begin
                        byte_d  = byte_q + 4'd1;
                        state_d = StData1;
                    end
                end
            end
            StSclEnd: if (last) state_d = StStop;
            StStop:   if (last) state_d = StTurn;
            StTurn: begin
                if (last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    // Left-align the received bytes so the first one lands in the MSBs.
                    dout_d  = rx_q << shamt;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        scl_d = high;
        sda_d = 1'b1;
        unique case (state_q)
            StStart, StSclBegin, StSclEnd, StStop: sda_d = 1'b0;
            StData1, StData2, StData3:             sda_d = rd_byte ? 1'b1 : tx_q[TxW-1];
            StAck1, StAck2, StAck3:                sda_d = rd_byte ? last_byte : 1'b1;
            default:                               sda_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= 16'd0;
            bit_q    <= 3'd0;
            byte_q   <= 4'd0;
            nbytes_q <= 4'd0;
            rw_q     <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            dout_q   <= '0;
            fail_q   <= 1'b1;
            done_q   <= 1'b0;
            sda_q    <= 1'b1;
            scl_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            nbytes_q <= nbytes_d;
            rw_q     <= rw_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            sda_q    <= sda_d;
            scl_q    <= scl_d;
        end
    end

    assign i2c_sclk      = scl_q ? 1'bz : 1'b0;
    assign i2c_sdat      = sda_q ? 1'bz : 1'b0;
    assign dout          = dout_q;
    assign i2c_idle      = (state_q == StIdle);
    assign i2c_fail      = fail_q;
    assign i2c_done_tick = done_q;

endmodule

// File: tb/tb_i2c_master_rw.sv
// Scoreboard bench for i2c_master_rw: behavioural I2C slave on the bus, expected transfer
// results queued at issue time and checked when the master reports end of transfer.
module tb_i2c_master_rw;

    localparam int TH = 19;
    localparam int TQ = 9;
    localparam int P  = 2 * TQ + TH + 6;  // one SCL bit period, including SCL-rise sync lag

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] din = 32'h0;
    logic [3:0]  nbytes = 4'd0;
    logic        wr_i2c = 1'b0;
    logic [23:0] dout;
    logic        i2c_idle, i2c_fail, i2c_done_tick;
    wire         scl, sda;
    logic        slave_scl_low = 1'b0;
    logic        slave_sda_low = 1'b0;

    pullup pu_scl (scl);
    pullup pu_sda (sda);
    assign scl = slave_scl_low ? 1'b0 : 1'bz;
    assign sda = slave_sda_low ? 1'b0 : 1'bz;

    i2c_master_rw #(
        .HALF     (TH),
        .QUTR     (TQ),
        .MAX_BYTES(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din          (din),
        .nbytes       (nbytes),
        .wr_i2c       (wr_i2c),
        .dout         (dout),
        .i2c_sclk     (scl),
        .i2c_sdat     (sda),
        .i2c_idle     (i2c_idle),
        .i2c_fail     (i2c_fail),
        .i2c_done_tick(i2c_done_tick)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    typedef struct {
        logic        fail;
        logic [23:0] dout;
        int          pulses;
        int          rx_n;
        logic [31:0] rx_word;
        int          mack_n;
        logic [7:0]  mack;
        logic        chk_time;
        int          t_min;
        int          t_max;
        logic        chk_stretch;
    } exp_t;

    exp_t sb_q[$];
    int   t_issue = 0;
    int   done_cnt = 0;

    function automatic exp_t mk(input logic f, input logic [23:0] d, input int p, input int rn,
                                input logic [31:0] rw_word, input int mn, input logic [7:0] m,
                                input logic ct, input int extra, input logic cs);
        exp_t e;
        e.fail = f; e.dout = d; e.pulses = p; e.rx_n = rn; e.rx_word = rw_word;
        e.mack_n = mn; e.mack = m; e.chk_time = ct; e.chk_stretch = cs;
        e.t_min = p * P + 3 * TH + 2 * TQ + extra;
        e.t_max = e.t_min + 20;
        return e;
    endfunction

    // Slave model configuration and observations.
    logic        nack_addr = 1'b0;
    logic [15:0] rd_word = 16'h0;
    int          stretch_byte = -1;
    int          stretch_bit = 3;
    int          starts = 0, rises = 0, pulses = 0, rx_n = 0, mack_n = 0;
    logic [31:0] rx_word = 32'h0;
    logic [7:0]  mack = 8'h0;
    logic        stop_seen = 1'b0;
    int          stretch_period = -1;

    initial begin
        logic ps, pd, cs, cd, active, first_fall, rw, reading, mnack, armed;
        logic [7:0] sh;
        int bitcnt, byte_idx, idx, stretch_cnt, t0;
        ps = 1'b1; pd = 1'b1; active = 1'b0; first_fall = 1'b0; rw = 1'b0; reading = 1'b0;
        mnack = 1'b0; armed = 1'b0; sh = 8'h0; bitcnt = 0; byte_idx = 0; stretch_cnt = 0;
        t0 = 0;
        forever begin
            @(negedge clk);
            cs = scl;
            cd = sda;
            if (stretch_cnt > 0) begin
                stretch_cnt--;
                if (stretch_cnt == 0) slave_scl_low = 1'b0;
            end
            if (!reset_n) begin
                active = 1'b0; slave_sda_low = 1'b0; slave_scl_low = 1'b0; stretch_cnt = 0;
            end else if (cs && ps && pd && !cd) begin
                active = 1'b1; first_fall = 1'b1; bitcnt = 0; byte_idx = 0; reading = 1'b0;
                mnack = 1'b0; armed = 1'b0; starts++; rises = 0; pulses = 0; rx_n = 0;
                rx_word = 32'h0; mack_n = 0; mack = 8'h0; stop_seen = 1'b0;
                stretch_period = -1; slave_sda_low = 1'b0;
            end else if (cs && ps && !pd && cd) begin
                active = 1'b0; stop_seen = 1'b1; slave_sda_low = 1'b0;
            end else if (active && !ps && cs) begin
                rises++;
                if (bitcnt < 8) sh = {sh[6:0], cd};
                else if (reading) begin
                    mack = {mack[6:0], cd};
                    mack_n++;
                    if (cd) mnack = 1'b1;
                end
            end else if (active && ps && !cs) begin
                if (first_fall) first_fall = 1'b0;
                else begin
                    if (armed) begin
                        stretch_period = cycle - t0;
                        armed = 1'b0;
                    end
                    pulses++;
                    bitcnt++;
                    if (bitcnt == 9) begin
                        bitcnt = 0;
                        byte_idx++;
                        reading = rw && !mnack;
                    end
                    if (bitcnt == 8) begin
                        if (!reading) begin
                            rx_word = {rx_word[23:0], sh};
                            rx_n++;
                            if (byte_idx == 0) rw = sh[0];
                            slave_sda_low = !(byte_idx == 0 && nack_addr);
                        end else slave_sda_low = 1'b0;
                    end else if (reading) begin
                        idx = 15 - 8 * (byte_idx - 1) - bitcnt;
                        slave_sda_low = (idx >= 0 && idx <= 15) ? !rd_word[idx] : 1'b0;
                    end else slave_sda_low = 1'b0;
                    if (byte_idx == stretch_byte && bitcnt == stretch_bit) begin
                        // Hold through DATA3/DATA1 plus 1000 cycles of the following DATA2.
                        slave_scl_low = 1'b1;
                        stretch_cnt = 2 * (TQ + 1) + 1000;
                        armed = 1'b1;
                        t0 = cycle;
                    end
                end
            end
            ps = cs;
            pd = cd;
        end
    end

    // Monitor: every done tick consumes one expected transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i2c_done_tick) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("fail", {31'd0, i2c_fail}, {31'd0, e.fail});
                    check("dout", {8'd0, dout}, {8'd0, e.dout});
                    check("scl_pulses", pulses, e.pulses);
                    check("slave_rx_count", rx_n, e.rx_n);
                    check("slave_rx_bytes", rx_word, e.rx_word);
                    check("master_ack_count", mack_n, e.mack_n);
                    check("master_ack_bits", {24'd0, mack}, {24'd0, e.mack});
                    check("stop_seen", {31'd0, stop_seen}, 32'd1);
                    if (e.chk_time) check_rng("done_latency", cycle - t_issue, e.t_min, e.t_max);
                    if (e.chk_stretch)
                        check_rng("stretch_period", stretch_period, P + 998, P + 1002);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] d, input logic [3:0] n);
        @(negedge clk);
        din = d;
        nbytes = n;
        wr_i2c = 1'b1;
        t_issue = cycle;
        @(negedge clk);
        wr_i2c = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, done_cnt >= target}, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int s0, d0, n, seen;
        repeat (3) @(negedge clk);
        check("reset_idle", {31'd0, i2c_idle}, 32'd1);
        check("reset_fail", {31'd0, i2c_fail}, 32'd1);
        check("reset_done", {31'd0, i2c_done_tick}, 32'd0);
        check("reset_dout", {8'd0, dout}, 32'd0);
        check("reset_scl", {31'd0, scl}, 32'd1);
        check("reset_sda", {31'd0, sda}, 32'd1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Write: address 0x34, data 0x1E, 0x00; the trailing 0x77 must not be sent.
        sb_q.push_back(mk(1'b0, 24'h0, 27, 3, 32'h00341E00, 0, 8'h0, 1'b1, 0, 1'b0));
        issue(32'h341E0077, 4'd3);
        wait_done(1, "write_timeout");

        // Read: address 0x35, slave returns 0xA5, 0x3C; master ACKs then NACKs.
        rd_word = 16'hA53C;
        sb_q.push_back(mk(1'b0, 24'hA53C00, 27, 1, 32'h35, 2, 8'h01, 1'b1, 0, 1'b0));
        issue(32'h35000000, 4'd3);
        wait_done(2, "read_timeout");

        // Address NACK: transfer ends after the address byte.
        nack_addr = 1'b1;
        sb_q.push_back(mk(1'b1, 24'h0, 9, 1, 32'h34, 0, 8'h0, 1'b1, 0, 1'b0));
        issue(32'h341E0000, 4'd3);
        wait_done(3, "nack_timeout");
        nack_addr = 1'b0;

        // Clock stretching on bit 3 of the data byte.
        stretch_byte = 1;
        sb_q.push_back(mk(1'b0, 24'h0, 18, 2, 32'h345A, 0, 8'h0, 1'b1, 1000, 1'b1));
        issue(32'h345A0000, 4'd2);
        wait_done(4, "stretch_timeout");
        stretch_byte = -1;

        // Reset during DATA2 of the first address bit (a 0, so SDA is driven low).
        s0 = starts;
        issue(32'h341E0000, 4'd3);
        n = 0;
        while ((starts == s0 || rises < 1) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reset_mid_reach_data2", {31'd0, rises >= 1}, 32'd1);
        repeat (3) @(negedge clk);
        check("pre_reset_sda_low", {31'd0, sda}, 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_reset_scl_released", {31'd0, scl}, 32'd1);
        check("mid_reset_sda_released", {31'd0, sda}, 32'd1);
        check("mid_reset_idle", {31'd0, i2c_idle}, 32'd1);
        check("mid_reset_fail", {31'd0, i2c_fail}, 32'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle", {31'd0, i2c_idle}, 32'd1);
        sb_q.push_back(mk(1'b0, 24'h0, 18, 2, 32'h34C3, 0, 8'h0, 1'b1, 0, 1'b0));
        issue(32'h34C30000, 4'd2);
        wait_done(5, "post_reset_timeout");

        // Illegal lengths are ignored.
        s0 = starts;
        d0 = done_cnt;
        issue(32'h34000000, 4'd0);
        repeat (50) @(negedge clk);
        check("nbytes0_idle", {31'd0, i2c_idle}, 32'd1);
        issue(32'h34000000, 4'd5);
        repeat (50) @(negedge clk);
        check("nbytes5_idle", {31'd0, i2c_idle}, 32'd1);
        check("illegal_no_start", starts, s0);
        check("illegal_no_done", done_cnt, d0);

        // wr_i2c held high: one transfer per IDLE visit (address-only, nbytes=1).
        sb_q.push_back(mk(1'b0, 24'h0, 9, 1, 32'h34, 0, 8'h0, 1'b0, 0, 1'b0));
        sb_q.push_back(mk(1'b0, 24'h0, 9, 1, 32'h34, 0, 8'h0, 1'b0, 0, 1'b0));
        s0 = starts;
        d0 = done_cnt;
        @(negedge clk);
        din = 32'h34000000;
        nbytes = 4'd1;
        wr_i2c = 1'b1;
        seen = 0;
        n = 0;
        while (seen < 2 && n < 5000) begin
            @(negedge clk);
            n++;
            if (i2c_done_tick) seen++;
        end
        wr_i2c = 1'b0;
        check("held_two_dones", seen, 2);
        repeat (100) @(negedge clk);
        check("held_starts", starts - s0, 2);
        check("held_done_count", done_cnt - d0, 2);
        check("held_final_idle", {31'd0, i2c_idle}, 32'd1);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
